// File: rtl/pb_conditioner.sv
// Push-button front end: polarity fix, 2-flop sync, per-bit debounce, press/release pulses.
// Define PB_AUTOREPEAT_EN to compile in the per-bit auto-repeat FSM that re-fires pb_press while held.
module pb_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES     = 500000,
   parameter int unsigned REPEAT_DELAY_CYCLES = 25000000,
   parameter int unsigned REPEAT_RATE_CYCLES  = 5000000,
   parameter bit          PB_ACTIVE_LOW       = 1'b0
) (
   input  logic       M_CLOCK,
   input  logic       reset,
   input  logic [3:0] pb_raw,
   output logic [3:0] pb_level,
   output logic [3:0] pb_press,
   output logic [3:0] pb_release
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

   if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY_CYCLES < 1 || REPEAT_RATE_CYCLES < 1) begin : g_param_check
      $error("pb_conditioner: cycle-count parameters must be >= 1");
   end

   logic [3:0]    norm;
   logic [3:0]    sync1;
   logic [3:0]    sync2;
   logic [CW-1:0] db_cnt [4];
   logic [3:0]    flip;
   logic [3:0]    rise;

   assign norm = PB_ACTIVE_LOW ? ~pb_raw : pb_raw;

   // flip: sync2 has now disagreed with pb_level for DEBOUNCE_CYCLES consecutive cycles
   always_comb begin
      flip = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         flip[i] = (sync2[i] != pb_level[i]) && (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1));
      end
      rise = flip & ~pb_level;
   end

   always_ff @(posedge M_CLOCK) begin
      if (reset) begin
         sync1      <= '0;
         sync2      <= '0;
         pb_level   <= '0;
         pb_release <= '0;
         for (int unsigned i = 0; i < 4; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         sync1      <= norm;
         sync2      <= sync1;
         pb_level   <= pb_level ^ flip;
         pb_release <= flip & pb_level;
         for (int unsigned i = 0; i < 4; i++) begin
            db_cnt[i] <= ((sync2[i] != pb_level[i]) && !flip[i]) ? db_cnt[i] + 1'b1 : '0;
         end
      end
   end

`ifdef PB_AUTOREPEAT_EN
   localparam int unsigned RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                                     REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
   localparam int unsigned RW = $clog2(RPT_MAX + 1);

   typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;

   rpt_state_t    state [4];
   logic [RW-1:0] rcnt  [4];
   logic [3:0]    rpt_fire;

   // A falling level (flip while held) suppresses a repeat due in the same cycle
   always_comb begin
      rpt_fire = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         rpt_fire[i] = !flip[i] &&
                       (((state[i] == DELAY)  && (rcnt[i] == RW'(REPEAT_DELAY_CYCLES - 1))) ||
                        ((state[i] == REPEAT) && (rcnt[i] == RW'(REPEAT_RATE_CYCLES - 1))));
      end
   end

   always_ff @(posedge M_CLOCK) begin
      if (reset) begin
         pb_press <= '0;
         for (int unsigned i = 0; i < 4; i++) begin
            state[i] <= IDLE;
            rcnt[i]  <= '0;
         end
      end else begin
         pb_press <= rise | rpt_fire;
         for (int unsigned i = 0; i < 4; i++) begin
            case (state[i])
               IDLE: begin
                  if (rise[i]) begin
                     state[i] <= DELAY;
                     rcnt[i]  <= '0;
                  end
               end
               DELAY: begin
                  if (flip[i]) begin
                     state[i] <= IDLE;
                  end else if (rpt_fire[i]) begin
                     state[i] <= REPEAT;
                     rcnt[i]  <= '0;
                  end else begin
                     rcnt[i] <= rcnt[i] + 1'b1;
                  end
               end
               REPEAT: begin
                  if (flip[i]) begin
                     state[i] <= IDLE;
                  end else if (rpt_fire[i]) begin
                     rcnt[i] <= '0;
                  end else begin
                     rcnt[i] <= rcnt[i] + 1'b1;
                  end
               end
               default: state[i] <= IDLE;
            endcase
         end
      end
   end
`else
   always_ff @(posedge M_CLOCK) begin
      if (reset) begin
         pb_press <= '0;
      end else begin
         pb_press <= rise;
      end
   end
`endif

endmodule

// File: doc/pb_conditioner.md
# pb_conditioner

Front-end conditioner for the four board push buttons. It synchronises `IO_PB` into the `M_CLOCK` domain, debounces each button independently, and produces clean levels, single-cycle press/release pulses and optional auto-repeat pulses. It sits between the board pins and the clock core / mode-select logic, replacing their raw `IO_PB` feeds. The auto-repeat pulses let a held button step hour/minute digits continuously in setup mode.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 500000: consecutive cycles a changed input must stay stable before it is accepted (10 ms at 50 MHz). Must be ≥1.
- `REPEAT_DELAY_CYCLES`, 25000000: hold time from the press pulse to the first repeat pulse. Must be ≥1.
- `REPEAT_RATE_CYCLES`, 5000000: period between later repeat pulses. Must be ≥1.
- `PB_ACTIVE_LOW`, 0: when 1, raw button input 0 means pressed.

Ports:
- `M_CLOCK`, input, 1: system clock. All logic is on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `pb_raw`, input, 4: asynchronous raw buttons (`IO_PB`).
- `pb_level`, output, 4: debounced level, 1 = pressed.
- `pb_press`, output, 4: one-cycle pulse on an accepted press, and on each auto-repeat.
- `pb_release`, output, 4: one-cycle pulse on an accepted release.

## Operation
- Polarity: normalise the raw input with `PB_ACTIVE_LOW`, then pass it through a 2-flop synchroniser per bit (`sync1`, `sync2`).
- Debounce, per bit:
  - A counter increments each cycle while `sync2 != pb_level`.
  - The counter clears in any cycle where they match.
  - When the counter reaches `DEBOUNCE_CYCLES`, `pb_level` toggles and the counter clears.
  - Counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
- Edge pulses, registered:
  - `pb_press[i]` asserts in the same cycle `pb_level[i]` rises.
  - `pb_release[i]` asserts in the same cycle `pb_level[i]` falls.
  - Both are never high together.
- Auto-repeat FSM, per bit. States are IDLE, DELAY and REPEAT.
  - IDLE → DELAY on a rising `pb_level`. Load the repeat counter.
  - DELAY: after `REPEAT_DELAY_CYCLES` cycles with the button still held, emit a `pb_press` pulse and go to REPEAT.
  - REPEAT: emit a `pb_press` pulse every `REPEAT_RATE_CYCLES` cycles.
  - Any state → IDLE in the cycle `pb_level` falls. No press pulse is emitted on that cycle.
- The four bits are fully independent. Simultaneous presses produce simultaneous pulses.
- Reset values:
  - `pb_level`, `pb_press` and `pb_release` = 0.
  - Synchroniser flops = 0 (after polarity normalisation).
  - All counters = 0 and every FSM in IDLE.
- A button held through reset deassertion is treated as a new press: `pb_level` rises and `pb_press` pulses after the normal debounce latency.
- Reset asserted mid-debounce or mid-repeat aborts the operation. No pulses are emitted in the cycles while `reset` is high.

## Timing
- Latency: a raw change first sampled at edge k (and held stable) updates `pb_level` at edge k+1+`DEBOUNCE_CYCLES`. The `pb_press`/`pb_release` pulse is valid in that same cycle.
- Glitches: a pulse or bounce stable for fewer than `DEBOUNCE_CYCLES` cycles at `sync2` produces no output change.
- Repeat timing, with the press pulse at cycle P:
  - First repeat at P+`REPEAT_DELAY_CYCLES`.
  - Later repeats at P+`REPEAT_DELAY_CYCLES`+n·`REPEAT_RATE_CYCLES`, for n ≥ 1.
- Every pulse is exactly one cycle wide. Consecutive pulses are separated by at least one low cycle when `REPEAT_RATE_CYCLES` ≥ 2. With a rate of 1, `pb_press` stays high continuously in REPEAT (legal).
- Release during the first repeat cycle: if `pb_level` falls in the same cycle a repeat would fire, the release wins. `pb_release` pulses and `pb_press` does not.

## Configuration
- `PB_AUTOREPEAT_EN` defined:
  - The auto-repeat FSM and its counter are compiled in.
  - Counter width is `$clog2(max(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES)+1)`.
- `PB_AUTOREPEAT_EN` undefined:
  - No repeat FSM or counters are synthesised.
  - `pb_press` pulses only once per accepted press.
  - `REPEAT_DELAY_CYCLES` and `REPEAT_RATE_CYCLES` are ignored.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY_CYCLES`=10, `REPEAT_RATE_CYCLES`=3 and `PB_ACTIVE_LOW`=0.
- Reset: hold `reset` for 3 cycles with `pb_raw`=0 → all outputs 0, and nothing toggles for 20 cycles afterwards.
- Clean press: `pb_raw[0]` 0→1 first sampled at edge k and held → `pb_level[0]` rises at k+5, and `pb_press[0]` is high for exactly cycle k+5. Then releasing at edge m → `pb_level[0]` falls at m+5 with a single `pb_release[0]` pulse.
- Bounce: toggle `pb_raw[1]` with a 1, 2, 3-cycle high/low pattern, then hold it at 1 → there are no pulses during the bouncing, and one `pb_press[1]` arrives 5 edges after the final stable edge.
- Auto-repeat (macro defined): hold `pb_raw[2]` with the press pulse at P → `pb_press[2]` pulses at P, P+10, P+13 and P+16. After release, no further press pulses and one `pb_release[2]`.
- Macro undefined: same stimulus → `pb_press[2]` pulses only at P.
- Independence and reset abort:
  - Press bits 0 and 3 on the same edge → identical simultaneous pulses on both bits.
  - Assert `reset` at P+5 while bit 3 is held → outputs clear immediately.
  - After reset deasserts → bit 3 re-presses after the debounce latency.
